branch_ctrl: RTL

ID-stage branch controller for the 5-stage pipeline. It sits on both sides of the ID-stage equality comparator:
- Upstream, it selects forwarded operands into the comparator and drives its beq/bne select.
- Downstream, it consumes the comparator's taken result, computes the branch target, and drives PC redirect and IF/ID flush.

It also owns the branch-operand hazard stall FSM, which stalls the front end until both compare operands are available.

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_hazard_detect.sv | 64 ++++++
 rtl/branch_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and stall-length constants for the ID-stage branch controller.
package branch_pkg;

    // Branch-operand hazard stall FSM states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Comparator operand source.
    typedef enum logic [0:0] {
        FWD_RF  = 1'b0,
        FWD_MEM = 1'b1
    } fwd_e;

    localparam int unsigned NEED_W = 2;

    // Stall cycles counted from first detection of each hazard kind.
    localparam int unsigned STALL_LOAD_EX  = 2;
    localparam int unsigned STALL_ALU_EX   = 1;
    localparam int unsigned STALL_LOAD_MEM = 1;

    // Larger of two stall needs.
    function automatic logic [NEED_W-1:0] max_need(input logic [NEED_W-1:0] a,
                                                   input logic [NEED_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Per-operand stall need and forward select for the two branch compare operands.
module branch_hazard_detect
    import branch_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0]   rs_i,
    input  logic [RA_W-1:0]   rt_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [RA_W-1:0]   ex_rd_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_mem_read_i,
    input  logic [RA_W-1:0]   mem_rd_i,
    output logic [NEED_W-1:0] rs_need_o_c,
    output logic [NEED_W-1:0] rt_need_o_c,
    output fwd_e              rs_fwd_o_c,
    output fwd_e              rt_fwd_o_c
);

    // Stall need of one operand; an EX match shadows a MEM match on the same register.
    function automatic logic [NEED_W-1:0] op_need(input logic [RA_W-1:0] r,
                                                  input logic ex_rw, input logic ex_mr,
                                                  input logic [RA_W-1:0] ex_rd,
                                                  input logic mem_rw, input logic mem_mr,
                                                  input logic [RA_W-1:0] mem_rd);
        logic [NEED_W-1:0] need;
        need = '0;
        if (r != '0) begin
            if (ex_rw && (ex_rd == r)) begin
                need = ex_mr ? NEED_W'(STALL_LOAD_EX) : NEED_W'(STALL_ALU_EX);
            end else if (mem_rw && mem_mr && (mem_rd == r)) begin
                need = NEED_W'(STALL_LOAD_MEM);
            end
        end
        return need;
    endfunction

    // Forward from MEM only for an ALU result not shadowed by a younger EX writer.
    function automatic fwd_e op_fwd(input logic [RA_W-1:0] r,
                                    input logic ex_rw, input logic [RA_W-1:0] ex_rd,
                                    input logic mem_rw, input logic mem_mr,
                                    input logic [RA_W-1:0] mem_rd);
        fwd_e sel;
        sel = FWD_RF;
        if ((r != '0) && !(ex_rw && (ex_rd == r)) && mem_rw && !mem_mr && (mem_rd == r)) begin
            sel = FWD_MEM;
        end
        return sel;
    endfunction

    // Evaluate both operands against the EX and MEM writers.
    always_comb begin
        rs_need_o_c = op_need(rs_i, ex_reg_write_i, ex_mem_read_i, ex_rd_i,
                              mem_reg_write_i, mem_mem_read_i, mem_rd_i);
        rt_need_o_c = op_need(rt_i, ex_reg_write_i, ex_mem_read_i, ex_rd_i,
                              mem_reg_write_i, mem_mem_read_i, mem_rd_i);
        rs_fwd_o_c  = op_fwd(rs_i, ex_reg_write_i, ex_rd_i,
                             mem_reg_write_i, mem_mem_read_i, mem_rd_i);
        rt_fwd_o_c  = op_fwd(rt_i, ex_reg_write_i, ex_rd_i,
                             mem_reg_write_i, mem_mem_read_i, mem_rd_i);
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: operand forwarding into the comparator, hazard
// stall FSM, branch target and PC redirect / IF/ID flush.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_branch,
    input  logic            id_bne,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [XLEN-1:0] id_pc_plus4,
    input  logic [XLEN-1:0] id_imm,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            mem_reg_write,
    input  logic            mem_mem_read,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] cmp_a,
    output logic [XLEN-1:0] cmp_b,
    output logic            cmp_bne,
    input  logic            cmp_taken,
    output logic            stall,
    output logic            pc_src,
    output logic            flush_ifid,
    output logic [XLEN-1:0] branch_target
);

    logic [NEED_W-1:0] rs_need_c;
    logic [NEED_W-1:0] rt_need_c;
    logic [NEED_W-1:0] req_need_c;
    fwd_e              rs_fwd_c;
    fwd_e              rt_fwd_c;
    state_e            state_q;
    state_e            state_d;
    logic [1:0]        rem_q;
    logic [1:0]        rem_d;
    logic              stall_c;
    logic              redirect_c;

    branch_hazard_detect #(
        .RA_W (RA_W)
    ) u_hazard (
        .rs_i            (id_rs),
        .rt_i            (id_rt),
        .ex_reg_write_i  (ex_reg_write),
        .ex_mem_read_i   (ex_mem_read),
        .ex_rd_i         (ex_rd),
        .mem_reg_write_i (mem_reg_write),
        .mem_mem_read_i  (mem_mem_read),
        .mem_rd_i        (mem_rd),
        .rs_need_o_c     (rs_need_c),
        .rt_need_o_c     (rt_need_c),
        .rs_fwd_o_c      (rs_fwd_c),
        .rt_fwd_o_c      (rt_fwd_c)
    );

    // Only a valid branch in ID can request a stall.
    assign req_need_c = (id_valid && id_branch) ? max_need(rs_need_c, rt_need_c) : '0;

    // Operand muxes track the current ID contents every cycle, stalled or not.
    assign cmp_a   = (rs_fwd_c == FWD_MEM) ? mem_alu_result : id_rs_data;
    assign cmp_b   = (rt_fwd_c == FWD_MEM) ? mem_alu_result : id_rt_data;
    assign cmp_bne = id_bne;

    // Target wraps modulo 2^XLEN.
    assign branch_target = id_pc_plus4 + (id_imm << 2);

    // Stall FSM next state; HOLD counts down without re-sampling hazards.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_need_c != '0) begin
                    stall_c = 1'b1;
                    if (req_need_c > 2'd1) begin
                        state_d = HOLD;
                        rem_d   = req_need_c - 2'd1;
                    end
                end
            end
            HOLD: begin
                stall_c = 1'b1;
                rem_d   = rem_q - 2'd1;
                if (rem_d == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
        if (rst) begin
            stall_c = 1'b0;
        end
    end

    // State and remaining-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Redirect on the first unstalled cycle of a taken branch.
    assign redirect_c = id_valid && id_branch && !stall_c && cmp_taken && !rst;
    assign stall      = stall_c;
    assign pc_src     = redirect_c;
    assign flush_ifid = redirect_c;

endmodule
